// File: rtl/llsc_dcache.sv
// Direct-mapped, write-back, write-allocate data cache with one word per line.
// Serves loads, stores and LL/SC from the pipeline and flushes dirty lines on halt.
module llsc_dcache #(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        datomic,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload,
  output logic [2:0]  dbg_state
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  // Handshakes: a pipeline request (REN/WEN) is held until the one-cycle dhit pulse;
  // a memory transfer (dREN/dWEN) completes in the first cycle it is high with dwait low.
  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FLUSH, S_DONE} state_t;
  state_t r_state, w_next;

  logic [31:0]      r_data [SETS];
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [SETS-1:0]  r_valid, r_dirty;
  logic             r_link_valid;
  logic [29:0]      r_link_addr;
  logic [29:0]      r_miss_addr;
  logic [IDX_W-1:0] r_fidx;

  logic [IDX_W-1:0] w_idx, w_midx;
  logic [TAG_W-1:0] w_tag, w_mtag;
  logic             w_req, w_sc, w_ll, w_hit, w_link_match;
  logic             w_wr_hit, w_start_miss, w_wb_done, w_fill_done, w_fidx_adv;
  logic             w_set_link, w_clr_link;
  logic [1:0]       w_unused_addr;

  assign w_idx         = dmemaddr[IDX_W+1:2];
  assign w_tag         = dmemaddr[31:IDX_W+2];
  assign w_midx        = r_miss_addr[IDX_W-1:0];
  assign w_mtag        = r_miss_addr[29:IDX_W];
  assign w_req         = dmemREN | dmemWEN;
  assign w_sc          = datomic & dmemWEN;
  assign w_ll          = datomic & dmemREN & ~dmemWEN;
  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_link_match  = r_link_valid && (r_link_addr == dmemaddr[31:2]);
  assign w_unused_addr = dmemaddr[1:0];
  assign dbg_state     = r_state;

  always_comb begin
    w_next       = r_state;
    dhit         = 1'b0;
    dmemload     = 32'd0;
    flushed      = 1'b0;
    dREN         = 1'b0;
    dWEN         = 1'b0;
    daddr        = 32'd0;
    dstore       = 32'd0;
    w_wr_hit     = 1'b0;
    w_start_miss = 1'b0;
    w_wb_done    = 1'b0;
    w_fill_done  = 1'b0;
    w_fidx_adv   = 1'b0;
    w_set_link   = 1'b0;
    w_clr_link   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_sc && !w_link_match) begin
            // A failing SC completes at once and touches neither cache nor memory.
            dhit       = 1'b1;
            w_clr_link = 1'b1;
          end else if (w_hit) begin
            dhit = 1'b1;
            if (dmemWEN) begin
              w_wr_hit   = 1'b1;
              dmemload   = {31'd0, w_sc};
              w_clr_link = w_link_match;
            end else begin
              dmemload   = r_data[w_idx];
              w_set_link = w_ll;
            end
          end else begin
            w_start_miss = 1'b1;
            w_next       = r_dirty[w_idx] ? S_WB : S_FILL;
          end
        end else if (halt) begin
          w_next = S_FLUSH;
        end
      end
      S_WB: begin
        dWEN   = 1'b1;
        daddr  = {r_tag[w_midx], w_midx, 2'b00};
        dstore = r_data[w_midx];
        if (!dwait) begin
          w_wb_done = 1'b1;
          w_next    = w_req ? S_FILL : S_IDLE;
        end
      end
      S_FILL: begin
        dREN  = 1'b1;
        daddr = {r_miss_addr, 2'b00};
        if (!dwait) begin
          w_fill_done = 1'b1;
          w_next      = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (r_dirty[r_fidx]) begin
          dWEN       = 1'b1;
          daddr      = {r_tag[r_fidx], r_fidx, 2'b00};
          dstore     = r_data[r_fidx];
          w_fidx_adv = !dwait;
        end else begin
          w_fidx_adv = 1'b1;
        end
        if (w_fidx_adv && (r_fidx == IDX_W'(SETS - 1))) w_next = S_DONE;
      end
      S_DONE: flushed = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_link_valid <= 1'b0;
      r_link_addr  <= '0;
      r_miss_addr  <= '0;
      r_fidx       <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_miss) r_miss_addr <= dmemaddr[31:2];
      if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
      if (w_wb_done || w_fill_done) r_dirty[w_midx] <= 1'b0;
      if (w_fill_done) r_valid[w_midx] <= 1'b1;
      if (w_fidx_adv) begin
        r_dirty[r_fidx] <= 1'b0;
        if (r_fidx != IDX_W'(SETS - 1)) r_fidx <= r_fidx + IDX_W'(1);
      end
      if (w_set_link) begin
        r_link_valid <= 1'b1;
        r_link_addr  <= dmemaddr[31:2];
      end else if (w_clr_link) begin
        r_link_valid <= 1'b0;
      end
    end
  end

  // Line storage needs no reset: valid bits gate every use of it.
  always_ff @(posedge CLK) begin
    if (w_wr_hit) r_data[w_idx] <= dmemstore;
    if (w_fill_done) begin
      r_data[w_midx] <= dload;
      r_tag[w_midx]  <= w_mtag;
    end
  end
endmodule

// File: tb/tb_llsc_dcache.sv
// Bench for llsc_dcache: directed scenarios plus random traffic checked against a
// flat word-memory model of the architectural state (no cache modelled).
module tb_llsc_dcache;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        halt = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, datomic = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0, dload = '0;
  logic        dwait = 1'b0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic [2:0]  dbg_state;

  llsc_dcache #(.SETS(8)) dut (
    .CLK(CLK), .RST(RST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .datomic(datomic), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
    .dmemload(dmemload), .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr),
    .dstore(dstore), .dwait(dwait), .dload(dload), .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 CLK = ~CLK;

  // ---- counters and scoreboard ----
  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: main memory and architectural word state ----
  logic [31:0] mem  [logic [29:0]];
  logic [31:0] arch [logic [29:0]];
  bit          lv = 1'b0;
  logic [29:0] la = '0;

  function automatic logic [31:0] def_word(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    return mem.exists(w) ? mem[w] : def_word(w);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [29:0] w);
    return arch.exists(w) ? arch[w] : mem_rd(w);
  endfunction

  task automatic model_op(input bit ren, input bit wen, input bit at, input logic [31:0] addr,
                          input logic [31:0] data, output logic [31:0] expv, output bit chk);
    logic [29:0] w;
    w = addr[31:2];
    expv = 32'd0;
    chk = 1'b0;
    if (wen) begin
      if (at) begin
        chk = 1'b1;
        if (lv && la == w) begin
          arch[w] = data;
          expv = 32'd1;
        end
        lv = 1'b0;
      end else begin
        arch[w] = data;
        if (la == w) lv = 1'b0;
      end
    end else if (ren) begin
      chk = 1'b1;
      expv = arch_rd(w);
      if (at) begin
        lv = 1'b1;
        la = w;
      end
    end
  endtask

  // ---- memory responder ----
  int          lat_fixed = 0;
  int          wait_cnt = 0;
  bit          xfer_active = 1'b0;
  int          ren_cycles = 0;
  logic [31:0] log_q[$];
  logic [31:0] kind_q[$];
  logic [31:0] data_q[$];

  always @(negedge CLK) begin
    if (dREN || dWEN) begin
      check("mem_excl", {31'd0, dREN & dWEN}, 32'd0);
      if (dREN) ren_cycles++;
      if (!xfer_active) begin
        xfer_active = 1'b1;
        wait_cnt = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
      end
      if (wait_cnt > 0) begin
        dwait = 1'b1;
        wait_cnt--;
      end else begin
        dwait = 1'b0;
        xfer_active = 1'b0;
        log_q.push_back(daddr);
        kind_q.push_back({31'd0, dWEN});
        if (dWEN) begin
          data_q.push_back(dstore);
          mem[daddr[31:2]] = dstore;
        end else begin
          dload = mem_rd(daddr[31:2]);
        end
      end
    end else begin
      xfer_active = 1'b0;
      dwait = 1'($urandom_range(0, 1));
    end
  end

  // ---- driver ----
  task automatic do_req(input string tag, input bit ren, input bit wen, input bit at,
                        input logic [31:0] addr, input logic [31:0] data, output int cyc);
    logic [31:0] expv;
    logic [31:0] e;
    bit          chk;
    bit          got;
    model_op(ren, wen, at, addr, data, expv, chk);
    if (chk) exp_q.push_back(expv);
    @(negedge CLK);
    dmemREN = ren; dmemWEN = wen; datomic = at; dmemaddr = addr; dmemstore = data;
    got = 1'b0;
    cyc = -1;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (dhit) begin
        got = 1'b1;
        cyc = c;
        break;
      end
      check({tag, "_nohit_load"}, dmemload, 32'd0);
      @(negedge CLK);
    end
    check({tag, "_done"}, {31'd0, got}, 32'd1);
    if (chk) begin
      e = exp_q.pop_front();
      if (got) check(tag, dmemload, e);
    end
    @(posedge CLK);
    #1;
    dmemREN = 1'b0; dmemWEN = 1'b0; datomic = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          op;
    bit          got;
    logic [31:0] a, d, d0, d1, d2;

    // reset state
    #1 RST = 1'b1;
    repeat (2) @(negedge CLK);
    #2;
    check("rst_dhit", {31'd0, dhit}, 32'd0);
    check("rst_dmemload", dmemload, 32'd0);
    check("rst_flushed", {31'd0, flushed}, 32'd0);
    check("rst_dren", {31'd0, dREN}, 32'd0);
    check("rst_dwen", {31'd0, dWEN}, 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // 1: cold load, memory busy three cycles
    lat_fixed = 3; ren_cycles = 0;
    do_req("t1_load", 1, 0, 0, 32'h40, 32'd0, cyc);
    check("t1_latency", cyc, 32'd5);
    check("t1_ren_cycles", ren_cycles, 32'd4);
    do_req("t1_rehit", 1, 0, 0, 32'h40, 32'd0, cyc);
    check("t1_rehit_latency", cyc, 32'd0);

    // 2: dirty victim written back before the fill
    lat_fixed = 1;
    do_req("t2_store", 0, 1, 0, 32'h40, 32'h0000_DEAD, cyc);
    check("t2_store_latency", cyc, 32'd0);
    log_q.delete(); kind_q.delete(); data_q.delete();
    do_req("t2_conflict_load", 1, 0, 0, 32'h60, 32'd0, cyc);
    check("t2_latency", cyc, 32'd5);
    check("t2_xfers", log_q.size(), 32'd2);
    check("t2_wb_kind", kind_q[0], 32'd1);
    check("t2_wb_addr", log_q[0], 32'h40);
    check("t2_wb_data", data_q[0], 32'h0000_DEAD);
    check("t2_fill_kind", kind_q[1], 32'd0);
    check("t2_fill_addr", log_q[1], 32'h60);
    do_req("t2_reload", 1, 0, 0, 32'h40, 32'd0, cyc);

    // 3: LL/SC pass, then SC broken by an intervening store
    lat_fixed = 0;
    do_req("t3_ll", 1, 0, 1, 32'h80, 32'd0, cyc);
    do_req("t3_sc_pass", 0, 1, 1, 32'h80, 32'd7, cyc);
    do_req("t3_load_7", 1, 0, 0, 32'h80, 32'd0, cyc);
    do_req("t3_ll2", 1, 0, 1, 32'h80, 32'd0, cyc);
    do_req("t3_store", 0, 1, 0, 32'h80, 32'h55, cyc);
    do_req("t3_sc_fail", 0, 1, 1, 32'h80, 32'd9, cyc);
    check("t3_sc_fail_latency", cyc, 32'd0);
    do_req("t3_load_55", 1, 0, 0, 32'h80, 32'd0, cyc);

    // 4: SC with no link
    log_q.delete(); kind_q.delete(); data_q.delete(); ren_cycles = 0;
    do_req("t4_sc_nolink", 0, 1, 1, 32'h100, 32'h1234, cyc);
    check("t4_latency", cyc, 32'd0);
    check("t4_no_xfers", log_q.size(), 32'd0);
    check("t4_no_ren", ren_cycles, 32'd0);
    do_req("t4_load", 1, 0, 0, 32'h100, 32'd0, cyc);

    // random traffic over four tags per set
    lat_fixed = -1;
    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 99);
      a = 32'h1000 + ($urandom_range(0, 3) << 5) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      d = $urandom;
      if (op < 40)      do_req("rnd_load", 1, 0, 0, a, d, cyc);
      else if (op < 65) do_req("rnd_store", 0, 1, 0, a, d, cyc);
      else if (op < 78) do_req("rnd_ll", 1, 0, 1, a, d, cyc);
      else if (op < 93) begin
        if (lv && $urandom_range(0, 1) == 1) a = {la, 2'b00};
        do_req("rnd_sc", 0, 1, 1, a, d, cyc);
      end else          do_req("rnd_both", 1, 1, 0, a, d, cyc);
    end

    // 6: reset in the middle of a fill
    lat_fixed = 0;
    do_req("t6_prime", 1, 0, 0, 32'h300, 32'd0, cyc);
    lat_fixed = 8;
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h320;
    repeat (3) @(negedge CLK);
    #1 check("t6_in_fill", {31'd0, dREN}, 32'd1);
    #1 RST = 1'b1;
    #1;
    check("t6_rst_dren", {31'd0, dREN}, 32'd0);
    check("t6_rst_dwen", {31'd0, dWEN}, 32'd0);
    check("t6_rst_dhit", {31'd0, dhit}, 32'd0);
    check("t6_rst_dmemload", dmemload, 32'd0);
    check("t6_rst_daddr", daddr, 32'd0);
    check("t6_rst_dstore", dstore, 32'd0);
    check("t6_rst_flushed", {31'd0, flushed}, 32'd0);
    @(negedge CLK);
    dmemREN = 1'b0; RST = 1'b0;
    arch.delete(); lv = 1'b0;
    lat_fixed = 0;
    do_req("t6_miss_after_rst", 1, 0, 0, 32'h300, 32'd0, cyc);
    check("t6_miss_latency", cyc, 32'd2);

    // 5: dirty sets 0, 3, 7 then halt
    lat_fixed = -1;
    d0 = $urandom; d1 = $urandom; d2 = $urandom;
    do_req("t5_st0", 0, 1, 0, 32'h200, d0, cyc);
    do_req("t5_st3", 0, 1, 0, 32'h20C, d1, cyc);
    do_req("t5_st7", 0, 1, 0, 32'h21C, d2, cyc);
    do_req("t5_ld1", 1, 0, 0, 32'h204, 32'd0, cyc);
    log_q.delete(); kind_q.delete(); data_q.delete();
    @(negedge CLK);
    halt = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      #1;
      if (flushed) begin
        got = 1'b1;
        break;
      end
    end
    check("t5_flushed", {31'd0, got}, 32'd1);
    check("t5_wb_count", log_q.size(), 32'd3);
    check("t5_wb0_addr", log_q[0], 32'h200);
    check("t5_wb1_addr", log_q[1], 32'h20C);
    check("t5_wb2_addr", log_q[2], 32'h21C);
    check("t5_wb0_data", data_q[0], d0);
    check("t5_wb1_data", data_q[1], d1);
    check("t5_wb2_data", data_q[2], d2);
    check("t5_mem0", mem_rd(30'h80), arch_rd(30'h80));
    check("t5_mem3", mem_rd(30'h83), arch_rd(30'h83));
    check("t5_mem7", mem_rd(30'h87), arch_rd(30'h87));
    dmemREN = 1'b1; dmemaddr = 32'h200;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1;
      check("t5_flushed_held", {31'd0, flushed}, 32'd1);
      check("t5_done_no_hit", {31'd0, dhit}, 32'd0);
      check("t5_done_no_ren", {31'd0, dREN}, 32'd0);
    end
    dmemREN = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
